// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: M-extension op encoding, MDU FSM states and the
// destination tag width used by forwarding and the scoreboard.
package riscv_pkg;

  localparam int TAG_WIDTH = 5;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } mult_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  function automatic logic is_div_op(input mult_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Radix-2 restoring divider on unsigned magnitudes. done pulses during the
// last iteration, with quotient/remainder presented combinationally.
module mdu_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [CW-1:0]   cnt_r;
  logic            run_r;
  logic [XLEN-1:0] quo_r;
  logic [XLEN-1:0] rem_r;
  logic [XLEN-1:0] dvs_r;
  logic [XLEN:0]   rem_shift_s;
  logic [XLEN:0]   diff_s;
  logic [XLEN-1:0] quo_s;
  logic [XLEN-1:0] rem_s;

  // One restoring step: trial-subtract the divisor from the shifted partial remainder
  always_comb begin
    rem_shift_s = {rem_r, quo_r[XLEN-1]};
    diff_s      = rem_shift_s - {1'b0, dvs_r};
    if (diff_s[XLEN]) begin
      rem_s = rem_shift_s[XLEN-1:0];
      quo_s = {quo_r[XLEN-2:0], 1'b0};
    end else begin
      rem_s = diff_s[XLEN-1:0];
      quo_s = {quo_r[XLEN-2:0], 1'b1};
    end
  end

  assign done      = run_r & (cnt_r == CW'(XLEN - 1));
  assign quotient  = quo_s;
  assign remainder = rem_s;

  // Iteration state: loaded on start, stepped once per cycle while running
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
      run_r <= 1'b0;
      quo_r <= '0;
      rem_r <= '0;
      dvs_r <= '0;
    end else if (flush) begin
      cnt_r <= '0;
      run_r <= 1'b0;
      quo_r <= '0;
      rem_r <= '0;
      dvs_r <= '0;
    end else if (start) begin
      cnt_r <= '0;
      run_r <= 1'b1;
      quo_r <= dividend;
      rem_r <= '0;
      dvs_r <= divisor;
    end else if (run_r) begin
      cnt_r <= cnt_r + CW'(1);
      quo_r <= quo_s;
      rem_r <= rem_s;
      run_r <= ~done;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/mdu_unit.sv
// RV32M/RV64M multiply/divide unit for EX: one op in flight, valid/ready on
// both sides, pipelined multiplier and early-out restoring divider.
module mdu_unit
  import riscv_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int MUL_STAGES    = 2,
  parameter int DIV_EARLY_OUT = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  mult_op_e             op,
  input  logic [XLEN-1:0]      op_a,
  input  logic [XLEN-1:0]      op_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_result,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 busy
);

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e           state_r, state_s;
  mult_op_e             op_r;
  logic [XLEN-1:0]      a_r, b_r;
  logic [TAG_WIDTH-1:0] tag_r;
  logic [2:0]           mul_cnt_r;
  logic                 div_run_r;
  logic                 out_valid_r;
  logic [XLEN-1:0]      out_result_r;
  logic [TAG_WIDTH-1:0] out_tag_r;

  logic                 accept_s, load_s, div_start_s;
  logic [XLEN-1:0]      result_s;
  logic                 a_sx_s, b_sx_s;
  logic [2*XLEN-1:0]    prod_s, prod_last_s;
  logic [XLEN-1:0]      mul_res_s;
  logic                 div_signed_s, is_rem_s, a_neg_s, b_neg_s;
  logic [XLEN-1:0]      abs_a_s, abs_b_s;
  logic                 special_s;
  logic [XLEN-1:0]      special_res_s, div_res_s;
  logic                 div_done_s;
  logic [XLEN-1:0]      div_quo_s, div_rem_s;

  assign in_ready   = (state_r == MDU_IDLE) & ~flush;
  assign accept_s   = in_valid & in_ready;
  assign busy       = (state_r != MDU_IDLE);
  assign out_valid  = out_valid_r;
  assign out_result = out_result_r;
  assign out_tag    = out_tag_r;

  // Multiplier: sign-extend both operands to 2*XLEN so one unsigned multiply covers all variants
  always_comb begin
    a_sx_s    = (op_r != MULHU) & a_r[XLEN-1];
    b_sx_s    = ((op_r == MUL) | (op_r == MULH)) & b_r[XLEN-1];
    prod_s    = {{XLEN{a_sx_s}}, a_r} * {{XLEN{b_sx_s}}, b_r};
    mul_res_s = (op_r == MUL) ? prod_last_s[XLEN-1:0] : prod_last_s[2*XLEN-1:XLEN];
  end

  generate
    if (MUL_STAGES == 1) begin : g_mul_comb
      assign prod_last_s = prod_s;
    end else begin : g_mul_pipe
      logic [2*XLEN-1:0] pipe_r [MUL_STAGES-1];

      // Product pipeline; the final stage is the result register itself
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < MUL_STAGES - 1; i++) pipe_r[i] <= '0;
        end else begin
          pipe_r[0] <= prod_s;
          for (int i = 1; i < MUL_STAGES - 1; i++) pipe_r[i] <= pipe_r[i-1];
        end
      end

      assign prod_last_s = pipe_r[MUL_STAGES-2];
    end
  endgenerate

  // Divide conditioning: magnitudes, single-cycle special cases and final sign fix-up
  always_comb begin
    div_signed_s  = (op_r == DIV) | (op_r == REM);
    is_rem_s      = (op_r == REM) | (op_r == REMU);
    a_neg_s       = div_signed_s & a_r[XLEN-1];
    b_neg_s       = div_signed_s & b_r[XLEN-1];
    abs_a_s       = a_neg_s ? -a_r : a_r;
    abs_b_s       = b_neg_s ? -b_r : b_r;
    special_s     = 1'b1;
    special_res_s = '0;
    if (b_r == '0) begin
      special_res_s = is_rem_s ? a_r : '1;
    end else if (div_signed_s && (a_r == XMIN) && (b_r == '1)) begin
      special_res_s = is_rem_s ? '0 : a_r;
    end else if ((DIV_EARLY_OUT != 0) && (abs_a_s < abs_b_s)) begin
      special_res_s = is_rem_s ? a_r : '0;
    end else begin
      special_s = 1'b0;
    end
    if (is_rem_s) begin
      div_res_s = a_neg_s ? -div_rem_s : div_rem_s;
    end else begin
      div_res_s = (a_neg_s ^ b_neg_s) ? -div_quo_s : div_quo_s;
    end
  end

  mdu_div_core #(.XLEN(XLEN)) u_div_core (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .start     (div_start_s),
    .dividend  (abs_a_s),
    .divisor   (abs_b_s),
    .done      (div_done_s),
    .quotient  (div_quo_s),
    .remainder (div_rem_s)
  );

  // FSM next state plus result-load and divider-start strobes
  always_comb begin
    state_s     = state_r;
    load_s      = 1'b0;
    result_s    = '0;
    div_start_s = 1'b0;
    if (flush) begin
      state_s = MDU_IDLE;
    end else begin
      case (state_r)
        MDU_IDLE: begin
          if (accept_s) state_s = is_div_op(op) ? MDU_DIV : MDU_MUL;
          else          state_s = MDU_IDLE;
        end
        MDU_MUL: begin
          if (mul_cnt_r == 3'(MUL_STAGES - 1)) begin
            state_s  = MDU_DONE;
            load_s   = 1'b1;
            result_s = mul_res_s;
          end else begin
            state_s = MDU_MUL;
          end
        end
        MDU_DIV: begin
          if (!div_run_r) begin
            if (special_s) begin
              state_s  = MDU_DONE;
              load_s   = 1'b1;
              result_s = special_res_s;
            end else begin
              div_start_s = 1'b1;
            end
          end else if (div_done_s) begin
            state_s  = MDU_DONE;
            load_s   = 1'b1;
            result_s = div_res_s;
          end else begin
            state_s = MDU_DIV;
          end
        end
        MDU_DONE: begin
          if (out_ready) state_s = MDU_IDLE;
          else           state_s = MDU_DONE;
        end
        default: state_s = MDU_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= MDU_IDLE;
    else          state_r <= state_s;
  end

  // Operand latch, cycle counters and the registered result/handshake outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || flush) begin
      op_r         <= MUL;
      a_r          <= '0;
      b_r          <= '0;
      tag_r        <= '0;
      mul_cnt_r    <= 3'd0;
      div_run_r    <= 1'b0;
      out_valid_r  <= 1'b0;
      out_result_r <= '0;
      out_tag_r    <= '0;
    end else begin
      if (accept_s) begin
        op_r      <= op;
        a_r       <= op_a;
        b_r       <= op_b;
        tag_r     <= in_tag;
        mul_cnt_r <= 3'd0;
        div_run_r <= 1'b0;
      end else if (state_r == MDU_MUL) begin
        mul_cnt_r <= mul_cnt_r + 3'd1;
      end else if (div_start_s) begin
        div_run_r <= 1'b1;
      end else begin
        mul_cnt_r <= mul_cnt_r;
      end
      if (load_s) begin
        out_valid_r  <= 1'b1;
        out_result_r <= result_s;
        out_tag_r    <= tag_r;
      end else if ((state_r == MDU_DONE) && out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Parametrised multi-cycle multiply/divide unit for the RV32M/RV64M extension.
- Successor to the free-running multiplier/divider pair inside the execute stage.
- Adds a valid/ready handshake on input and output, a pipelined multiplier with selectable depth, RISC-V corner-case handling, divider early-out, and tag passthrough for forwarding/scoreboard.
- Instantiated in EX; its result merges into the EX writeback mux.

Parameters:
- XLEN, 32: operand/result width; legal values 32 or 64.
- MUL_STAGES, 2: multiply latency in cycles; legal range 1..4.
- DIV_EARLY_OUT, 1: when 1, divides with |dividend| < |divisor| complete in 1 cycle.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  kill any in-flight op (EX flush)
- in_valid  in  1  op request
- in_ready  out  1  unit can accept an op
- op  in  mult_op_e  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- op_a  in  XLEN  rs1 value
- op_b  in  XLEN  rs2 value
- in_tag  in  TAG_WIDTH  destination tag, returned with the result
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_result  out  XLEN  result
- out_tag  out  TAG_WIDTH  tag of the result
- busy  out  1  op in flight or result pending

Behaviour:
- Clock is clk; reset is reset_n, asynchronous, active-low.
- Reset values: state IDLE, out_valid 0, out_result 0, out_tag 0, busy 0; in_ready 1 from the first cycle after reset.
- Only one op is outstanding at a time.
- in_ready = (state==IDLE) & ~flush.
- Accept occurs when in_valid & in_ready; op, operands and tag are latched.
- FSM states:
  - IDLE: on accept, go to MUL (multiply ops) or DIV (divide ops).
  - MUL: count MUL_STAGES cycles, then go to DONE.
  - DIV: run the iteration counter, then go to DONE.
  - DONE: out_valid=1; on out_ready, go to IDLE.
- busy = (state!=IDLE).
- Latency: accept at cycle 0, out_valid high at cycle L.
  - Multiply: L = MUL_STAGES.
  - Divide special/early-out: L = 1.
  - Normal divide: L = XLEN+1 (1 cycle to take absolute values, XLEN radix-2 restoring iterations).
- Multiply signedness: MUL and MULH are signed×signed; MULHSU is signed op_a × unsigned op_b; MULHU is unsigned×unsigned.
  - Form the 2*XLEN product.
  - MUL returns product[XLEN-1:0]; the other multiply ops return product[2*XLEN-1:XLEN].
- Divide:
  - Operate on magnitudes.
  - Quotient is negated when sign(a)^sign(b) for DIV.
  - Remainder takes the sign of the dividend for REM.
  - DIVU/REMU are fully unsigned.
- Divide by zero (op_b==0): quotient = all ones, remainder = op_a, L = 1.
- Signed overflow (DIV/REM, op_a = most negative, op_b = -1): quotient = op_a, remainder = 0, L = 1.
- If both special cases could apply, divide by zero has priority.
- Early-out (DIV_EARLY_OUT=1 and |a| < |b|, b != 0): quotient 0, remainder op_a (unmodified), L = 1.
- Output hold: out_result and out_tag stay stable while out_valid & ~out_ready; no new accept is allowed in DONE.
- Flush, in any state:
  - Next cycle state=IDLE, out_valid=0, busy=0.
  - A pending DONE result is discarded.
  - Flush has priority over a simultaneous accept (the op is not taken) and over out_ready.
- out_valid & out_ready in the same cycle: return to IDLE; in_ready rises the next cycle (no back-to-back accept in the handshake cycle).
- Reset asserted mid-operation: all state and outputs return immediately to reset values.
- No X propagation: operand registers clear on flush.

Decomposition:
- riscv_pkg:
  - reuse mult_op_e;
  - add mdu_state_e {MDU_IDLE, MDU_MUL, MDU_DIV, MDU_DONE};
  - TAG_WIDTH already lives there.
- Sub-module mdu_div_core:
  - XLEN-iteration restoring divider with start/done handshake;
  - magnitude inputs;
  - counter of $clog2(XLEN)+1 bits.
- The multiply pipeline stays inline as MUL_STAGES register stages on the product.

Test Plan:
- MULHU, MULH and MUL with a=b=0xFFFFFFFF, MUL_STAGES=2:
  - MULHU returns 0xFFFFFFFE;
  - MULH returns 0x00000000;
  - MUL returns 0x00000001;
  - each has out_valid at cycle 2.
- DIV 7/0 and REM 7/0:
  - DIV returns 0xFFFFFFFF at cycle 1;
  - REM returns 0x00000007;
  - DIVU 7/0 returns 0xFFFFFFFF.
- DIV and REM of 0x80000000 / 0xFFFFFFFF:
  - DIV returns 0x80000000;
  - REM returns 0x00000000;
  - both at cycle 1.
- DIV and REM of -7/2:
  - DIV returns 0xFFFFFFFD at cycle 33;
  - REM returns 0xFFFFFFFF;
  - DIVU 5/9 with early-out returns 0 at cycle 1; with DIV_EARLY_OUT=0 it returns 0 at cycle 33.
- Backpressure: hold out_ready=0 for 5 cycles after DONE.
  - out_result and out_tag are stable;
  - in_ready stays 0;
  - a new in_valid is ignored;
  - the op is released on out_ready.
- Flush and reset:
  - flush at cycle 10 of a DIV: out_valid never rises and in_ready=1 the next cycle;
  - flush together with in_valid in IDLE: no accept;
  - reset_n low mid-MUL: all outputs are at reset values immediately.
